// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, one single-position shift per clock for amt cycles; optional zero flag via SEQ_SHIFTER_FLAGS_EN
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [CW-1:0]    amt,
    output logic [WIDTH-1:0] sout,
    output logic             busy,
`ifdef SEQ_SHIFTER_FLAGS_EN
    output logic             done,
    output logic             zf
`else
    output logic             done
`endif
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [1:0]       op_r, op_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] sout_nx, stepped;
    logic             upd;
    assign busy = state != IDLE;
    assign done = state == DONE;
    // one-position shift of the working value under the latched op
    always_comb begin
        stepped = op_r == 2'b01 ? {sout[WIDTH-2:0], 1'b0} :
                  op_r == 2'b10 ? {1'b0, sout[WIDTH-1:1]} :
                  op_r == 2'b11 ? {sout[WIDTH-1], sout[WIDTH-1:1]} : sout;
    end
    // next state, next working value and count; pass or zero count skips SHIFT
    always_comb begin
        state_nx = state;
        op_nx    = op_r;
        cnt_nx   = cnt;
        sout_nx  = sout;
        upd      = 1'b0;
        case (state)
            IDLE: if (start) begin
                sout_nx  = in;
                op_nx    = shift;
                cnt_nx   = amt;
                upd      = 1'b1;
                state_nx = (amt == '0 || shift == 2'b00) ? DONE : SHIFT;
            end
            SHIFT: begin
                sout_nx  = stepped;
                cnt_nx   = cnt - CW'(1);
                upd      = 1'b1;
                state_nx = cnt == CW'(1) ? DONE : SHIFT;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_r  <= 2'b00;
            cnt   <= '0;
            sout  <= '0;
        end else begin
            state <= state_nx;
            op_r  <= op_nx;
            cnt   <= cnt_nx;
            sout  <= sout_nx;
        end
    end
`ifdef SEQ_SHIFTER_FLAGS_EN
    // zero flag tracks sout, updated only on edges that load or shift it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) zf <= 1'b0;
        else if (upd) zf <= sout_nx == '0;
    end
`else
    logic unused_upd;
    assign unused_upd = upd;
`endif
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed-vector scoreboard bench for seq_shifter
module tb_seq_shifter;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [15:0] in = '0, sout;
    logic [1:0]  shift = '0;
    logic [3:0]  amt = '0;
    logic        busy, done;
`ifdef SEQ_SHIFTER_FLAGS_EN
    logic        zf;
`endif
    int checks = 0, failures = 0, cyc = 0, busy_cnt = 0;
    logic prev_done = 1'b0;
    typedef struct {logic [15:0] s; logic z; int c; int b;} exp_t;
    exp_t q[$];

    seq_shifter #(.WIDTH(16), .CW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in(in), .shift(shift), .amt(amt),
`ifdef SEQ_SHIFTER_FLAGS_EN
        .zf(zf),
`endif
        .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
            prev_done = 1'b0;
        end else begin
            busy_cnt = busy ? busy_cnt + 1 : 0;
            if (done) begin
                chk("done_width", int'(prev_done), 0);
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sout", int'(sout), int'(e.s));
                    chk("latency_cycle", cyc, e.c);
                    chk("busy_cycles", busy_cnt, e.b);
`ifdef SEQ_SHIFTER_FLAGS_EN
                    chk("zf", int'(zf), int'(e.z));
`endif
                end
            end
            prev_done = done;
        end
    end

    // poke: 1 = re-pulse start during SHIFT, 2 = re-pulse start during DONE
    task automatic run(input logic [15:0] d, input logic [1:0] sh, input logic [3:0] a,
                       input int poke, input logic [15:0] exp_s);
        exp_t e;
        int eff;
        @(negedge clk);
        start = 1'b1; in = d; shift = sh; amt = a;
        eff = (sh == 2'b00) ? 0 : int'(a);
        e.s = exp_s; e.z = exp_s == 16'h0000; e.c = cyc + 1 + eff; e.b = 1 + eff;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0; in = 16'($urandom); shift = 2'($urandom); amt = 4'($urandom);
        for (int i = 0; i < 40 && !done; i++) begin
            if (poke == 1 && i == 1) begin
                start = 1'b1; in = 16'hFFFF;
            end else start = 1'b0;
            @(negedge clk);
        end
        if (!done) chk("timeout", 0, 1);
        if (poke == 2) begin
            start = 1'b1; in = 16'hFFFF; shift = 2'b01; amt = 4'd1;
        end else start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_sout", int'(sout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
`ifdef SEQ_SHIFTER_FLAGS_EN
        chk("rst_zf", int'(zf), 0);
`endif
        @(negedge clk); reset = 1'b1;
        // reset asserted mid-SHIFT
        @(negedge clk);
        start = 1'b1; in = 16'h82C5; shift = 2'b01; amt = 4'd10;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_sout", int'(sout), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk); reset = 1'b1;
        run(16'h00FF, 2'b10, 4'd2, 0, 16'h003F);
        run(16'h82C5, 2'b01, 4'd1, 0, 16'h058A);
        run(16'h82C5, 2'b01, 4'd4, 0, 16'h2C50);
        run(16'h82C5, 2'b10, 4'd3, 0, 16'h1058);
        run(16'h82C5, 2'b11, 4'd3, 0, 16'hF058);
        run(16'h82C5, 2'b00, 4'd7, 0, 16'h82C5);
        run(16'h82C5, 2'b01, 4'd0, 0, 16'h82C5);
        run(16'h1234, 2'b01, 4'd2, 1, 16'h48D0);
        run(16'h1234, 2'b10, 4'd4, 2, 16'h0123);
        run(16'hA5A5, 2'b01, 4'd15, 0, 16'h8000);
        run(16'h8000, 2'b01, 4'd1, 0, 16'h0000);
        run(16'h8000, 2'b11, 4'd15, 0, 16'hFFFF);
        run(16'h8000, 2'b10, 4'd15, 0, 16'h0001);
        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
